// File: rtl/data_ram_resp_pkg.sv
// data_ram_resp_pkg: shared state encodings, lane masks and enable levels for the data-RAM responder.
package data_ram_resp_pkg;

    typedef enum logic {
        DR_IDLE    = 1'b0,
        DR_RD_WAIT = 1'b1
    } dr_state_t;

    // Big-endian lanes: B0 is byte offset 0 (bits 31:24)
    localparam logic [3:0] LANE_B0 = 4'b1000;
    localparam logic [3:0] LANE_B1 = 4'b0100;
    localparam logic [3:0] LANE_B2 = 4'b0010;
    localparam logic [3:0] LANE_B3 = 4'b0001;

    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic WRITE_ENABLE = 1'b1;

endpackage

// File: rtl/data_ram_resp_bram_be.sv
// bram_be: single-port 32-bit block RAM with per-byte write enables and a registered read port.
module bram_be
    import data_ram_resp_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic [3:0]        i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_din,
    output logic [31:0]       o_dout
);

    logic [31:0] r_mem [0:(2**ADDR_W)-1];
    logic [31:0] r_dout;

    always_ff @(posedge clk) begin
        if (|(i_we & LANE_B0)) r_mem[i_addr][31:24] <= i_din[31:24];
        if (|(i_we & LANE_B1)) r_mem[i_addr][23:16] <= i_din[23:16];
        if (|(i_we & LANE_B2)) r_mem[i_addr][15:8]  <= i_din[15:8];
        if (|(i_we & LANE_B3)) r_mem[i_addr][7:0]   <= i_din[7:0];
        if (i_re) r_dout <= r_mem[i_addr];
    end

    assign o_dout = r_dout;

endmodule

// File: rtl/data_ram_resp.sv
// data_ram_resp: MIPS data-memory responder; byte-enabled BRAM with a one-cycle read stall,
// range decode, last-read hold register and a one-cycle error pulse for out-of-region accesses.
module data_ram_resp
    import data_ram_resp_pkg::*;
#(
    parameter int          ADDR_W    = 12,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        stall_req_o,
    output logic        err_o
);

    dr_state_t   r_state, w_next;
    logic        r_rd_ok, r_err;
    logic [31:0] r_hold, w_ram_q, w_rd_data;
    logic        w_in_range, w_wr, w_rd;
    logic [3:0]  w_we;
    logic        w_unused;

    assign w_in_range = addr_i[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2];
    assign w_unused   = &{1'b0, addr_i[1:0]};

    // Requests are only accepted in IDLE; RD_WAIT ignores ce_i/we_i so a stalled read is not relaunched
    always_comb begin
        w_wr        = !rst && r_state == DR_IDLE && ce_i == CHIP_ENABLE && we_i == WRITE_ENABLE;
        w_rd        = !rst && r_state == DR_IDLE && ce_i == CHIP_ENABLE && we_i != WRITE_ENABLE;
        w_we        = (w_wr && w_in_range) ? sel_i : 4'b0000;
        w_next      = w_rd ? DR_RD_WAIT : DR_IDLE;
        w_rd_data   = r_rd_ok ? w_ram_q : 32'h0;
        stall_req_o = w_rd;
        data_o      = r_state == DR_RD_WAIT ? w_rd_data : r_hold;
    end

    always_ff @(posedge clk) begin
        r_state <= rst ? DR_IDLE : w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ok <= 1'b0;
            r_hold  <= 32'h0;
            r_err   <= 1'b0;
        end else begin
            if (w_rd) r_rd_ok <= w_in_range;
            if (r_state == DR_RD_WAIT) r_hold <= w_rd_data;
            r_err <= (w_wr && !w_in_range) || (r_state == DR_RD_WAIT && !r_rd_ok);
        end
    end

    assign err_o = r_err;

    bram_be #(.ADDR_W(ADDR_W)) u_bram (
        .clk    (clk),
        .i_we   (w_we),
        .i_re   (w_rd),
        .i_addr (addr_i[ADDR_W+1:2]),
        .i_din  (data_i),
        .o_dout (w_ram_q)
    );

endmodule

// File: tb/tb_data_ram_resp.sv
// tb_data_ram_resp: transaction-level memory model drives per-cycle expectations; one compare process checks them.
module tb_data_ram_resp;

    logic        clk = 1'b0;
    logic        rst, ce_i, we_i;
    logic [31:0] addr_i, data_i, data_o;
    logic [3:0]  sel_i;
    logic        stall_req_o, err_o;

    data_ram_resp #(.ADDR_W(12), .BASE_ADDR(32'h0)) dut (
        .clk         (clk),
        .rst         (rst),
        .ce_i        (ce_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .sel_i       (sel_i),
        .data_i      (data_i),
        .data_o      (data_o),
        .stall_req_o (stall_req_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:4095];
    logic [31:0] hold;
    logic        errp;
    int          checks = 0, errors = 0;
    logic        chk = 1'b0, chkd = 1'b0, lit_en = 1'b0;
    logic        e_stall, e_err;
    logic [31:0] e_data, lit_val;

    function automatic logic inr(input logic [31:0] a);
        return a[31:14] == 18'h0;
    endfunction

    always @(negedge clk) begin
        if (chk) begin
            checks++;
            if (stall_req_o !== e_stall) begin
                errors++;
                $display("FAIL stall t=%0t got=%b want=%b", $time, stall_req_o, e_stall);
            end
            checks++;
            if (err_o !== e_err) begin
                errors++;
                $display("FAIL err t=%0t got=%b want=%b", $time, err_o, e_err);
            end
            if (chkd) begin
                checks++;
                if (data_o !== e_data) begin
                    errors++;
                    $display("FAIL data t=%0t got=%h want=%h", $time, data_o, e_data);
                end
            end
            if (lit_en) begin
                checks++;
                if (data_o !== lit_val) begin
                    errors++;
                    $display("FAIL literal t=%0t got=%h want=%h", $time, data_o, lit_val);
                end
            end
        end
    end

    task automatic cyc(input logic r, input logic c, input logic w, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d,
                       input logic es, input logic cd, input logic [31:0] ed, input logic ee);
        @(posedge clk);
        #1;
        rst = r; ce_i = c; we_i = w; addr_i = a; sel_i = s; data_i = d;
        e_stall = es; chkd = cd; e_data = ed; e_err = ee; lit_en = 1'b0; chk = 1'b1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        cyc(0, 1, 1, a, s, d, 0, 1, hold, errp);
        errp = !inr(a);
        if (inr(a))
            for (int k = 0; k < 4; k++)
                if (s[k]) mem[a[13:2]][8*k +: 8] = d[8*k +: 8];
    endtask

    task automatic rd(input logic [31:0] a);
        logic [31:0] v;
        cyc(0, 1, 0, a, 4'($urandom), $urandom, 1, 1, hold, errp);
        errp = 1'b0;
        v = inr(a) ? mem[a[13:2]] : 32'h0;
        cyc(0, 1'($urandom), 1'($urandom), {18'h0, 14'($urandom)}, 4'($urandom), $urandom, 0, 1, v, 0);
        hold = v;
        errp = !inr(a);
    endtask

    task automatic rdl(input logic [31:0] a, input logic [31:0] lit);
        rd(a);
        lit_val = lit;
        lit_en = 1'b1;
    endtask

    task automatic idle();
        cyc(0, 0, 1'($urandom), $urandom, 4'($urandom), $urandom, 0, 1, hold, errp);
        errp = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom;
        if ($urandom_range(0, 7) == 0) begin
            if (a[31:14] == 18'h0) a[14] = 1'b1;
        end else begin
            a = {18'h0, 6'h0, 6'($urandom), 2'($urandom)};
        end
        return a;
    endfunction

    initial begin
        rst = 1'b1; ce_i = 1'b0; we_i = 1'b0; addr_i = '0; sel_i = '0; data_i = '0;
        hold = 32'h0; errp = 1'b0;
        @(posedge clk);
        cyc(1, 0, 0, 32'h0, 4'h0, 32'h0, 0, 1, 32'h0, 0);
        cyc(1, 1, 0, 32'h10, 4'hF, 32'h0, 0, 1, 32'h0, 0);
        cyc(1, 0, 0, 32'h0, 4'h0, 32'h0, 0, 1, 32'h0, 0);
        for (int i = 0; i < 64; i++) wr(32'(i * 4), 4'hF, $urandom);
        idle();
        wr(32'h10, 4'hF, 32'hDEADBEEF);
        rdl(32'h10, 32'hDEADBEEF);
        wr(32'h20, 4'hF, 32'h11223344);
        wr(32'h21, 4'b0100, 32'hAAAAAAAA);
        rdl(32'h20, 32'h11AA3344);
        wr(32'h30, 4'hF, 32'h11223344);
        wr(32'h32, 4'b0011, 32'h55665566);
        rdl(32'h30, 32'h11225566);
        wr(32'h30, 4'b0000, 32'hFFFFFFFF);
        idle();
        rdl(32'h30, 32'h11225566);
        rdl(32'h10, 32'hDEADBEEF);
        rdl(32'h20, 32'h11AA3344);
        idle();
        lit_val = 32'h11AA3344; lit_en = 1'b1;
        idle();
        wr(32'h0000_4000, 4'hF, 32'h12345678);
        idle();
        rdl(32'h0000_4000, 32'h0);
        idle();
        idle();
        rd(32'h0);
        // Reset lands on RD_WAIT: data is not defined that cycle, only stall/err
        cyc(0, 1, 0, 32'h10, 4'hF, 32'h0, 1, 1, hold, errp);
        cyc(1, 1, 1, 32'h10, 4'hF, 32'hFFFFFFFF, 0, 0, 32'h0, 0);
        hold = 32'h0; errp = 1'b0;
        idle();
        lit_val = 32'h0; lit_en = 1'b1;
        rdl(32'h10, 32'hDEADBEEF);
        for (int i = 0; i < 600; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 4) wr(rand_addr(), 4'($urandom), $urandom);
            else if (r < 8) rd(rand_addr());
            else idle();
        end
        idle();
        @(posedge clk);
        #1;
        chk = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_ram_resp.md
Name: data_ram_resp

Overview:
- Responder end of the data-memory interface driven by the MIPS memory-access stage.
- The initiator sends ce, we, a byte address, a 4-bit byte select and write data. This block answers with read data.
- Storage is a synchronous-read, byte-enabled block RAM. Each read therefore costs one wait cycle, which the block signals to the pipeline controller through a stall request.
- Writes complete in a single cycle.

Parameters:
- ADDR_W, 12, word-address width; depth = 2^ADDR_W 32-bit words.
- BASE_ADDR, 32'h0000_0000, byte base address of the decoded region; must be aligned to 2^(ADDR_W+2).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- ce_i  in  1  chip enable from the memory-access stage
- we_i  in  1  1 = write, 0 = read (valid while ce_i=1)
- addr_i  in  32  byte address; bits [1:0] are ignored, lanes come from sel_i
- sel_i  in  4  byte-lane enables, big-endian: sel_i[3] = bits 31:24 (byte offset 0), sel_i[0] = bits 7:0 (offset 3)
- data_i  in  32  write data, already replicated or shifted into lanes by the initiator
- data_o  out  32  read data, full word; lane extraction is done by the initiator
- stall_req_o  out  1  stall request to the pipeline controller
- err_o  out  1  one-cycle pulse: access outside the decoded region

Behaviour:
- Reset values: data_o=0, err_o=0, state=IDLE. stall_req_o=0 while rst=1. RAM contents are not cleared.
- Address handling:
  - in_range = (addr_i[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]).
  - Word index = addr_i[ADDR_W+1:2].
- The FSM has two states, IDLE and RD_WAIT.
- IDLE:
  - ce_i=0: no action.
  - ce_i=1, we_i=1, in_range: on the clock edge write data_i into the lanes enabled by sel_i; other lanes are unchanged. sel_i=0000 is a legal no-op. No stall; stay in IDLE.
  - ce_i=1, we_i=1, out of range: write dropped; err_o=1 next cycle; stay in IDLE.
  - ce_i=1, we_i=0: stall_req_o=1, driven combinationally in the same cycle.
    - The RAM read is launched on this edge.
    - Go to RD_WAIT and latch in_range into rd_ok.
- RD_WAIT:
  - The RAM output is valid this cycle.
  - data_o is driven combinationally: the RAM output if rd_ok, otherwise 0. The value is also captured into a hold register on this edge.
  - stall_req_o=0.
  - If rd_ok=0, err_o=1 next cycle.
  - Always return to IDLE.
  - ce_i/we_i are ignored in this state: the request is the same stalled request and must not be relaunched.
- In IDLE, data_o is the hold register, i.e. the last completed read value. It stays stable until the next read completes.
- Read latency: the read request cycle plus one wait cycle. The pipeline consumes data_o at the end of RD_WAIT.
- Back-to-back reads go IDLE, RD_WAIT, IDLE, RD_WAIT; each read stalls exactly one cycle.
- A write followed by a read of the same word on the next cycle returns the new data, because the write has committed before the read launches.
- Read-during-write to the same address in one cycle cannot occur, because reads and writes are exclusive per request.
- rst asserted in RD_WAIT:
  - next state is IDLE; data_o=0 and err_o=0;
  - the pending read is discarded;
  - no RAM write occurs while rst=1.
- err_o is never asserted while rst=1. For a given access it is high for exactly one cycle.

Decomposition:
- Shared defines file: state encodings (DR_IDLE, DR_RD_WAIT) and the lane masks LANE_B0..LANE_B3 = 4'b1000..4'b0001. ChipEnable and WriteEnable reuse the existing global defines.
- One sub-module, bram_be:
  - 2^ADDR_W x 32 array with a synchronous read port;
  - per-lane write enable, one port, registered output;
  - written so that it infers block RAM.
- The FSM, range decode, hold register and error pulse live in data_ram_resp.

Test Plan:
- Full-word write then read: write addr 0x10, sel 1111, data 0xDEADBEEF. Read addr 0x10 on the next cycle → stall_req_o=1 for one cycle, then data_o=0xDEADBEEF in RD_WAIT.
- Byte-lane write: pre-fill word 0x20 with 0x11223344. Write addr 0x21, sel 0100, data 0xAAAAAAAA. Read 0x20 → 0x11AA3344.
- Halfword write: pre-fill word 0x30 with 0x11223344. Write addr 0x32, sel 0011, data 0x55665566. Read 0x30 → 0x11225566. A write with sel 0000 leaves the word unchanged and raises no error.
- Back-to-back reads: read 0x10 then 0x20 → stall pattern 1,0,1,0. data_o delivers 0xDEADBEEF then 0x11AA3344, and holds 0x11AA3344 afterwards in IDLE.
- Out of range with ADDR_W=12 and BASE 0:
  - write 0x0000_4000 → no RAM change, err_o=1 for one cycle;
  - read 0x0000_4000 → data_o=0, err_o=1 for one cycle after RD_WAIT.
- Reset mid-read: launch a read of 0x10 and assert rst during RD_WAIT → next cycle state=IDLE, data_o=0, stall_req_o=0, err_o=0. A subsequent read of 0x10 still returns 0xDEADBEEF.
